apa102_ws2812_bridge: RTL and testbench

// - Tiny Tapeout user core: receives an APA102 (SCK/SDA) LED stream and re-emits it as a WS2812 one-wire stream.
// - Two WS2812 outputs:
//   - raw colour on uo_out[0];
//   - colour scaled by the APA102 5-bit global brightness on uo_out[1].
// - The top-level TT wrapper drives rst = ~rst_n.

---
 rtl/apa102_ws2812_pkg.sv | 15 +
 rtl/apa102_ws2812_bridge_if.sv | 13 +
 rtl/ws2812_tx.sv | 80 ++++++++
 rtl/apa102_ws2812_bridge.sv | 108 ++++++++++
 tb/tb_apa102_ws2812_bridge.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apa102_ws2812_pkg.sv
// Shared constants and types for the APA102 to WS2812 bridge.
// Holds the LED record layout and the transmitter state encoding.
package apa102_ws2812_pkg;
  localparam logic [2:0] APA_HDR     = 3'b111;
  localparam int         START_ZEROS = 32;

  typedef struct packed {
    logic [4:0] bright;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } led_t;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
endpackage

// File: rtl/apa102_ws2812_bridge_if.sv
// Tiny Tapeout user-core pin bundle.
// The wrapper or bench is the master; the core is the slave.
interface apa102_ws2812_bridge_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/ws2812_tx.sv
// Dual-pin WS2812 serialiser: raw and scaled GRB words share one bit timer.
// ready is high when idle or on the final cycle of the last bit, allowing gapless reload.
module ws2812_tx
  import apa102_ws2812_pkg::*;
#(
  parameter int T0H_CYC = 4,
  parameter int T1H_CYC = 8,
  parameter int BIT_CYC = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] raw_grb,
  input  logic [23:0] scl_grb,
  output logic        dout_raw,
  output logic        dout_scl,
  output logic        busy,
  output logic        ready
);
  localparam int            CW       = $clog2(BIT_CYC);
  localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] T0H      = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H      = CW'(T1H_CYC);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cyc_q;
  logic [4:0]    bit_q;
  logic [23:0]   raw_q, scl_q;
  logic          last_cyc, last_bit;

  assign last_cyc = (cyc_q == LAST_CYC);
  assign last_bit = (bit_q == 5'd23);

  always_ff @(posedge clk) begin
    if (rst) state_q <= TX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = (state_q == TX_IDLE) || (last_cyc && last_bit);
    case (state_q)
      TX_IDLE: if (load) state_d = TX_SEND;
      TX_SEND: if (last_cyc && last_bit && !load) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      bit_q <= '0;
    end else if (load) begin
      cyc_q <= '0;
      bit_q <= '0;
    end else if (state_q == TX_SEND) begin
      if (last_cyc) begin
        cyc_q <= '0;
        bit_q <= bit_q + 5'd1;
      end else begin
        cyc_q <= cyc_q + CW'(1);
      end
    end
  end

  // Data shifters carry no reset; the state register gates the pins.
  always_ff @(posedge clk) begin
    if (load) begin
      raw_q <= raw_grb;
      scl_q <= scl_grb;
    end else if (state_q == TX_SEND && last_cyc) begin
      raw_q <= {raw_q[22:0], 1'b0};
      scl_q <= {scl_q[22:0], 1'b0};
    end
  end

  assign busy     = (state_q == TX_SEND);
  assign dout_raw = busy && (cyc_q < (raw_q[23] ? T1H : T0H));
  assign dout_scl = busy && (cyc_q < (scl_q[23] ? T1H : T0H));
endmodule

// File: rtl/apa102_ws2812_bridge.sv
// APA102 receiver, one-entry frame queue and brightness scaler feeding ws2812_tx.
// uo_out: [0] raw, [1] scaled, [2] sticky overflow, [3] busy.
module apa102_ws2812_bridge
  import apa102_ws2812_pkg::*;
#(
  parameter int T0H_CYC = 4,
  parameter int T1H_CYC = 8,
  parameter int BIT_CYC = 12
) (
  input logic                   clk,
  input logic                   rst,
  apa102_ws2812_bridge_if.slave tt
);
  localparam logic [5:0] ZERO_MAX = 6'(START_ZEROS);

  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [4:0] br);
    logic [12:0] prod;
    prod = 13'(c) * 13'({1'b0, br} + 6'd1);
    return prod[12:5];
  endfunction

  logic sck_p0, sck_p1, sck_p2, sda_p0, sda_p1, sck_rise;

  always_ff @(posedge clk) begin
    if (rst) {sck_p0, sck_p1, sck_p2} <= '0;
    else     {sck_p0, sck_p1, sck_p2} <= {tt.ui_in[0], sck_p0, sck_p1};
  end

  always_ff @(posedge clk) begin
    {sda_p0, sda_p1} <= {tt.ui_in[1], sda_p0};
  end

  assign sck_rise = sck_p1 & ~sck_p2;

  // Receiver: the zero-run realigns bit_cnt on every start frame.
  logic [31:0] shift_q, word_nxt;
  logic [4:0]  bit_cnt;
  logic [5:0]  zero_run, zero_nxt;
  logic        frame_done;

  always_comb begin
    word_nxt   = {shift_q[30:0], sda_p1};
    zero_nxt   = sda_p1 ? 6'd0 : ((zero_run == ZERO_MAX) ? zero_run : zero_run + 6'd1);
    frame_done = sck_rise && (zero_nxt != ZERO_MAX) && (bit_cnt == 5'd31) &&
                 (word_nxt[31:29] == APA_HDR) && (word_nxt != 32'hFFFF_FFFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      zero_run <= '0;
    end else if (sck_rise) begin
      zero_run <= zero_nxt;
      bit_cnt  <= (zero_nxt == ZERO_MAX) ? 5'd0 : bit_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (sck_rise) shift_q <= word_nxt;
  end

  // Holding register between receiver and transmitter.
  led_t hold_q;
  logic hold_full, overflow, tx_ready, tx_busy, tx_load, dout_raw, dout_scl;

  assign tx_load = hold_full & tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (frame_done && hold_full) overflow <= 1'b1;
      if (frame_done && !hold_full) hold_full <= 1'b1;
      else if (tx_load)             hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (frame_done && !hold_full)
      hold_q <= {word_nxt[28:24], word_nxt[7:0], word_nxt[15:8], word_nxt[23:16]};
  end

  ws2812_tx #(
    .T0H_CYC(T0H_CYC),
    .T1H_CYC(T1H_CYC),
    .BIT_CYC(BIT_CYC)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .load    (tx_load),
    .raw_grb ({hold_q.g, hold_q.r, hold_q.b}),
    .scl_grb ({scale_chan(hold_q.g, hold_q.bright),
               scale_chan(hold_q.r, hold_q.bright),
               scale_chan(hold_q.b, hold_q.bright)}),
    .dout_raw(dout_raw),
    .dout_scl(dout_scl),
    .busy    (tx_busy),
    .ready   (tx_ready)
  );

  assign tt.uo_out  = {4'b0000, tx_busy | hold_full, overflow, dout_scl, dout_raw};
  assign tt.uio_out = 8'h00;
  assign tt.uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, tt.ena, tt.ui_in[7:2], tt.uio_in};
endmodule

// File: tb/tb_apa102_ws2812_bridge.sv
// Bench for apa102_ws2812_bridge: drives APA102 words at SCK=clk/4 and decodes
// both WS2812 pins back into 24-bit GRB words compared against expected colours.
module tb_apa102_ws2812_bridge;
  localparam int T0H_CYC = 4;
  localparam int T1H_CYC = 8;
  localparam int BIT_CYC = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apa102_ws2812_bridge_if bus ();

  apa102_ws2812_bridge #(
    .T0H_CYC(T0H_CYC), .T1H_CYC(T1H_CYC), .BIT_CYC(BIT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tt (bus)
  );

  int checks = 0;
  int errors = 0;

  // Pulse decoder: each fall turns the high time into a bit, 24 bits make a word.
  logic [23:0] raw_q[$];
  logic [23:0] scl_q[$];
  int          rise_q[$];
  logic [23:0] dsh[2];
  int          hcnt[2];
  int          bcnt[2];
  int          last_rise[2];
  logic        prev[2];
  int          bad_pulse = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        hcnt[p] <= 0;
        bcnt[p] <= 0;
        prev[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        prev[p] <= bus.uo_out[p];
        if (bus.uo_out[p]) begin
          hcnt[p] <= hcnt[p] + 1;
          if (!prev[p]) begin
            last_rise[p] <= cyc;
            if (bcnt[p] != 0 && (cyc - last_rise[p]) != BIT_CYC) bad_pulse <= bad_pulse + 1;
            if (p == 0) rise_q.push_back(cyc);
          end
        end else if (prev[p]) begin
          hcnt[p] <= 0;
          if (hcnt[p] != T1H_CYC && hcnt[p] != T0H_CYC) bad_pulse <= bad_pulse + 1;
          dsh[p] <= {dsh[p][22:0], (hcnt[p] == T1H_CYC)};
          if (bcnt[p] == 23) begin
            bcnt[p] <= 0;
            if (p == 0) raw_q.push_back({dsh[p][22:0], (hcnt[p] == T1H_CYC)});
            else        scl_q.push_back({dsh[p][22:0], (hcnt[p] == T1H_CYC)});
          end else begin
            bcnt[p] <= bcnt[p] + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.ui_in = {6'd0, b, 1'b0};
    repeat (2) @(negedge clk);
    bus.ui_in = {6'd0, b, 1'b1};
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
    bus.ui_in = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (4) @(negedge clk);
    while (bus.uo_out[3] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(bus.uo_out[3]), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_one(input string tag, input int base, input logic [23:0] er,
                           input logic [23:0] es);
    chk({tag, "_nraw"}, 32'(raw_q.size() - base), 32'd1);
    chk({tag, "_nscl"}, 32'(scl_q.size() - base), 32'd1);
    if (raw_q.size() > base) chk({tag, "_raw"}, 32'(raw_q[base]), 32'(er));
    if (scl_q.size() > base) chk({tag, "_scl"}, 32'(scl_q[base]), 32'(es));
  endtask

  function automatic logic [7:0] mscale(input int c, input int br);
    return 8'((c * (br + 1)) / 32);
  endfunction

  typedef struct {
    logic [31:0] word;
    bit          garbage;
    logic [23:0] raw;
    logic [23:0] scl;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int base, rb, n, cnt;
    logic [31:0] w;
    logic [23:0] er, es;
    int br;

    vecs[0] = '{32'hFF00_00FF, 1'b0, 24'h00FF00, 24'h00FF00};
    vecs[1] = '{32'hE010_2040, 1'b0, 24'h204010, 24'h010200};
    vecs[2] = '{32'hF0AA_55CC, 1'b1, 24'h55CCAA, 24'h2D6C5A};
    vecs[3] = '{32'hE5FF_8001, 1'b0, 24'h8001FF, 24'h18002F};

    rst = 1'b1;
    bus.ena = 1'b1;
    bus.ui_in = 8'h00;
    bus.uio_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_uo_out", 32'(bus.uo_out), 32'd0);
    chk("rst_uio_out", 32'(bus.uio_out), 32'd0);
    chk("rst_uio_oe", 32'(bus.uio_oe), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_uo_out", 32'(bus.uo_out), 32'd0);

    for (int i = 0; i < 4; i++) begin
      base = raw_q.size();
      if (vecs[i].garbage) send_word(32'h5A5A_5A5A);
      send_word(32'h0);
      send_word(vecs[i].word);
      wait_idle($sformatf("vec%0d", i));
      check_one($sformatf("vec%0d", i), base, vecs[i].raw, vecs[i].scl);
    end

    // End frame after an LED frame: busy spans exactly 24 bit periods of output.
    base = raw_q.size();
    send_word(32'h0);
    send_word(32'hE010_2040);
    cnt = 0;
    fork
      send_word(32'hFFFF_FFFF);
      begin
        n = 0;
        while (!bus.uo_out[0] && n < 2000) begin
          @(negedge clk);
          n++;
        end
        while (bus.uo_out[3] && cnt < 2000) begin
          cnt++;
          @(negedge clk);
        end
      end
    join
    chk("endframe_busy_len", 32'(cnt), 32'(24 * BIT_CYC));
    wait_idle("endframe");
    check_one("endframe", base, 24'h204010, 24'h010200);

    // Three frames back to back: third is dropped and overflow sticks.
    do_reset();
    base = raw_q.size();
    rb = rise_q.size();
    send_word(32'h0);
    send_word(32'hFF00_00FF);
    send_word(32'hE010_2040);
    repeat (4) @(negedge clk);
    chk("ovf_before", 32'(bus.uo_out[2]), 32'd0);
    send_word(32'hF0AA_55CC);
    repeat (4) @(negedge clk);
    chk("ovf_set", 32'(bus.uo_out[2]), 32'd1);
    wait_idle("ovf");
    chk("ovf_sticky", 32'(bus.uo_out[2]), 32'd1);
    chk("ovf_nframes", 32'(raw_q.size() - base), 32'd2);
    if (raw_q.size() >= base + 2) begin
      chk("ovf_f1_raw", 32'(raw_q[base]), 32'h00FF00);
      chk("ovf_f2_raw", 32'(raw_q[base + 1]), 32'h204010);
    end
    if (scl_q.size() >= base + 2) chk("ovf_f2_scl", 32'(scl_q[base + 1]), 32'h010200);
    if (rise_q.size() >= rb + 48) chk("b2b_gap", 32'(rise_q[rb + 24] - rise_q[rb + 23]), 32'(BIT_CYC));
    else                          chk("b2b_rises", 32'(rise_q.size() - rb), 32'd48);
    do_reset();
    chk("ovf_cleared", 32'(bus.uo_out), 32'd0);

    // Reset five bit periods into a transmission.
    send_word(32'h0);
    send_word(32'hE5FF_8001);
    n = 0;
    while (!bus.uo_out[3] && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5 * BIT_CYC + 2) @(negedge clk);
    chk("midrst_busy_before", 32'(bus.uo_out[3]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_uo_out", 32'(bus.uo_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = raw_q.size();
    send_word(32'h0);
    send_word(32'hF0AA_55CC);
    wait_idle("after_rst");
    check_one("after_rst", base, 24'h55CCAA, 24'h2D6C5A);

    for (int i = 0; i < 6; i++) begin
      w = {3'b111, 29'($urandom)};
      if (w == 32'hFFFF_FFFF) w[0] = 1'b0;
      br = int'(w[28:24]);
      er = {w[15:8], w[7:0], w[23:16]};
      es = {mscale(int'(w[15:8]), br), mscale(int'(w[7:0]), br), mscale(int'(w[23:16]), br)};
      base = raw_q.size();
      send_word(32'h0);
      send_word(w);
      wait_idle($sformatf("rnd%0d", i));
      check_one($sformatf("rnd%0d", i), base, er, es);
    end

    chk("pulse_shapes", 32'(bad_pulse), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
